// File: rtl/cam_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the 4-bit camera-style link (receiver and serializer).
//   CAM_NIB_W          nibble width on the link
//   CAM_WORD_W         reassembled word width
//   CAM_NIBS_PER_WORD  nibbles per word, least-significant nibble first
//   cam_rx_state_t     receiver FSM states
//   cam_shift_in       shifts one nibble into the top of a word (LSN-first)
// -----------------------------------------------------------------------------
package cam_pkg;

  localparam int CAM_NIB_W         = 4;
  localparam int CAM_WORD_W        = 32;
  localparam int CAM_NIBS_PER_WORD = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } cam_rx_state_t;

  // New nibble enters at the top; after 8 shifts the first nibble sits in [3:0].
  function automatic logic [CAM_WORD_W-1:0] cam_shift_in(
    input logic [CAM_WORD_W-1:0] sh,
    input logic [CAM_NIB_W-1:0]  nib
  );
    return {nib, sh[CAM_WORD_W-1:CAM_NIB_W]};
  endfunction

endpackage

// File: rtl/cam_deserializer_if.sv
// -----------------------------------------------------------------------------
// cam_deserializer_if
// Valid/ready word stream leaving the deserializer.
//   data_o   head word of the receive FIFO
//   valid_o  FIFO non-empty
//   ready_i  consumer accepts data_o when valid_o & ready_i
// master: the deserializer (drives data/valid); slave: the consumer.
// -----------------------------------------------------------------------------
interface cam_deserializer_if;
  import cam_pkg::*;

  logic [CAM_WORD_W-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/cam_rx_fifo.sv
// -----------------------------------------------------------------------------
// cam_rx_fifo
// Small synchronous FIFO with a combinational head word.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   i_push/i_data write request and word
//   i_pop         read request (ignored when empty)
//   o_full/o_empty occupancy flags
//   o_head        word at the read pointer (0 after reset)
//   o_drop        push refused because FIFO full and no pop this cycle
// A push while full is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module cam_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still takes the word if the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cam_deserializer.sv
// -----------------------------------------------------------------------------
// cam_deserializer
// Receive end of the 4-bit link (pclk / sync / data). The link is oversampled in
// the clk_i domain, one nibble is captured per pclk rising edge while sync is
// high, and 32-bit words are rebuilt least-significant nibble first and queued.
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   cam_pclk_i          link pixel clock (asynchronous)
//   cam_sync_i          frame active
//   cam_data_i[3:0]     link nibble
//   clr_i               clears overflow_o and frame_err_cnt_o
//   out_if (master)     data_o / valid_o / ready_i word stream
//   busy_o              receiver inside a frame
//   frame_err_o         1-cycle pulse: frame ended with a partial word
//   frame_err_cnt_o     saturating count of frame errors
//   overflow_o          sticky: completed word dropped on a full FIFO
// -----------------------------------------------------------------------------
module cam_deserializer
  import cam_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cam_pclk_i,
  input  logic                 cam_sync_i,
  input  logic [CAM_NIB_W-1:0] cam_data_i,
  input  logic                 clr_i,
  cam_deserializer_if.master   out_if,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic [7:0]           frame_err_cnt_o,
  output logic                 overflow_o
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RECV = RECV;

  // ---------------------------------------------------------------- sync chain
  // pclk, sync and data see identical delay so their relative timing survives.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic                 r_pclk;
    logic                 r_sync;
    logic [CAM_NIB_W-1:0] r_data;
    logic                 w_pclk_in;
    logic                 w_sync_in;
    logic [CAM_NIB_W-1:0] w_data_in;

    if (gi == 0) begin : g_src
      assign w_pclk_in = cam_pclk_i;
      assign w_sync_in = cam_sync_i;
      assign w_data_in = cam_data_i;
    end else begin : g_chain
      assign w_pclk_in = g_sync[gi-1].r_pclk;
      assign w_sync_in = g_sync[gi-1].r_sync;
      assign w_data_in = g_sync[gi-1].r_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_pclk <= 1'b0;
        r_sync <= 1'b0;
        r_data <= '0;
      end else begin
        r_pclk <= w_pclk_in;
        r_sync <= w_sync_in;
        r_data <= w_data_in;
      end
    end
  end

  logic                 w_pclk_s;
  logic                 w_sync_s;
  logic [CAM_NIB_W-1:0] w_data_s;
  logic                 r_pclk_d;
  logic                 r_sync_d;

  assign w_pclk_s = g_sync[SYNC_STAGES-1].r_pclk;
  assign w_sync_s = g_sync[SYNC_STAGES-1].r_sync;
  assign w_data_s = g_sync[SYNC_STAGES-1].r_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pclk_d <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_pclk_d <= w_pclk_s;
      r_sync_d <= w_sync_s;
    end
  end

  logic w_pclk_rise;
  logic w_sync_rise;
  logic w_sync_fall;

  assign w_pclk_rise = w_pclk_s & ~r_pclk_d;
  assign w_sync_rise = w_sync_s & ~r_sync_d;
  assign w_sync_fall = ~w_sync_s & r_sync_d;

  // ------------------------------------------------------------ frame arming
  // The chain resets to 0, so a sync held high across reset would look like a
  // fresh rising edge once it propagates. Only arm after the chain has filled
  // with real samples and sync has been seen low, so reception restarts on a
  // genuine frame start.
  logic [SYNC_STAGES:0] r_prime;
  logic                 r_armed;
  logic                 w_start;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prime <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      r_armed <= r_armed | (r_prime[SYNC_STAGES] & ~w_sync_s);
    end
  end

  assign w_start = w_sync_rise & r_armed;

  // ------------------------------------------------------------- receive FSM
  logic [0:0]            r_state;
  logic [2:0]            r_nib_cnt;
  logic [CAM_WORD_W-1:0] r_sh;
  logic                  r_push;
  logic                  r_frame_err;
  logic [CAM_WORD_W-1:0] w_sh_next;

  assign w_sh_next = cam_shift_in(r_sh, w_data_s);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_nib_cnt   <= '0;
      r_sh        <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        // Frame start wins; a coincident pclk edge becomes nibble 0.
        r_state <= S_RECV;
        if (w_pclk_rise) begin
          r_sh      <= w_sh_next;
          r_nib_cnt <= 3'd1;
        end else begin
          r_nib_cnt <= '0;
        end
      end else if (r_state == S_RECV) begin
        if (w_sync_fall) begin
          r_state   <= S_IDLE;
          r_nib_cnt <= '0;
          if (r_nib_cnt != '0) begin
            r_frame_err <= 1'b1;
          end
        end else if (w_pclk_rise && w_sync_s) begin
          r_sh      <= w_sh_next;
          r_nib_cnt <= r_nib_cnt + 1'b1;  // wraps to 0 on the last nibble
          if (r_nib_cnt == 3'(CAM_NIBS_PER_WORD - 1)) begin
            r_push <= 1'b1;               // r_sh holds the full word next cycle
          end
        end
      end
    end
  end

  assign busy_o      = (r_state == S_RECV);
  assign frame_err_o = r_frame_err;

  // -------------------------------------------------------------------- FIFO
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  w_pop;
  logic [CAM_WORD_W-1:0] w_head;

  assign w_pop = ~w_empty & out_if.ready_i;

  cam_rx_fifo #(
    .WIDTH (CAM_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (r_push),
    .i_data  (r_sh),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_drop  (w_drop)
  );

  assign out_if.data_o  = w_head;
  assign out_if.valid_o = ~w_empty;

  // ------------------------------------------------------ status and counters
  // A new event in the same cycle as clr_i takes precedence over the clear.
  logic [7:0] r_err_cnt;
  logic       r_overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_frame_err) begin
        if (clr_i) begin
          r_err_cnt <= 8'd1;
        end else if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end else if (clr_i) begin
        r_err_cnt <= '0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign frame_err_cnt_o = r_err_cnt;
  assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_cam_deserializer.sv
// -----------------------------------------------------------------------------
// tb_cam_deserializer
// Drives the link with a behavioural pclk/sync/data model and checks the word
// stream against a nibble-level model of the receiver (words are built from the
// nibble list of each frame, partial tails count as frame errors, words beyond
// the FIFO depth are dropped while the consumer stalls).
// -----------------------------------------------------------------------------
module tb_cam_deserializer;
  import cam_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk;
  logic       sync;
  logic [3:0] data;
  logic       clr;
  logic       busy;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       ovf;

  cam_deserializer_if u_if ();

  cam_deserializer #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cam_pclk_i      (pclk),
    .cam_sync_i      (sync),
    .cam_data_i      (data),
    .clr_i           (clr),
    .out_if          (u_if.master),
    .busy_o          (busy),
    .frame_err_o     (frame_err),
    .frame_err_cnt_o (err_cnt),
    .overflow_o      (ovf)
  );

  always #9 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  logic [3:0]  nibs[$];
  int          exp_err_cnt = 0;
  logic        exp_ovf     = 1'b0;
  int          err_pulses  = 0;
  logic        prev_err    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Compare process: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) begin
        err_pulses++;
        check("frame_err_pulse_width", {31'd0, prev_err}, 32'd0);
      end
      prev_err = frame_err;
      if (u_if.valid_o && u_if.ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_word: got %h expected none", u_if.data_o);
        end else begin
          check("pop_data", u_if.data_o, exp_q.pop_front());
        end
        pop_log.push_back(u_if.data_o);
        $display("pop data=%h", u_if.data_o);
      end
    end else begin
      prev_err = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_word(input logic [31:0] w);
    for (int j = 0; j < 8; j++) nibs.push_back(w[4*j +: 4]);
  endtask

  // Model: whole groups of 8 nibbles become words (LSN first); a tail is an error.
  task automatic model_frame();
    logic [31:0] w;
    for (int k = 0; k < nibs.size() / 8; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = w | (32'(nibs[8*k+j]) << (4*j));
      if (!u_if.ready_i && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(w);
    end
    if (nibs.size() % 8 != 0 && exp_err_cnt < 255) exp_err_cnt++;
  endtask

  task automatic nib_pulse(input logic [3:0] d, input int ph, input bit skew);
    int s;
    s = skew ? int'($urandom_range(0, ph - 1)) : 0;
    repeat (s) @(posedge clk);
    if (skew) #($urandom_range(1, 7));
    else #2;
    data = d;
    repeat (ph - s) @(posedge clk);
    #2 pclk = 1'b1;
    repeat (ph) @(posedge clk);
    #2 pclk = 1'b0;
  endtask

  task automatic send_frame(input int ph, input bit skew);
    model_frame();
    $display("frame nibbles=%0d", nibs.size());
    @(posedge clk);
    #2 sync = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < nibs.size(); i++) begin
      nib_pulse(nibs[i], ph, skew);
      if (i == 0) begin
        @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
      end
    end
    repeat (3) @(posedge clk);
    #2 sync = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    nibs.delete();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, u_if.valid_o}, 32'd0);
    check({tag, "_data"}, u_if.data_o, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    check({tag, "_overflow"}, {31'd0, ovf}, 32'd0);
  endtask

  int pulses_before;

  initial begin
    rst = 1'b1; pclk = 1'b0; sync = 1'b0; data = '0; clr = 1'b0;
    u_if.ready_i = 1'b0;
    repeat (4) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);

    // 1: two words, consumer stalled; head must hold until released.
    add_word(32'h12345678);
    send_frame(3, 1'b0);
    add_word(32'hABCDEF01);
    send_frame(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold_valid", {31'd0, u_if.valid_o}, 32'd1);
      check("t1_hold_data", u_if.data_o, 32'h12345678);
    end
    @(posedge clk);
    #2 u_if.ready_i = 1'b1;
    wait_drain("t1_drain");
    check("t1_pop_count", pop_log.size(), 32'd2);
    if (pop_log.size() == 2) begin
      check("t1_word0", pop_log[0], 32'h12345678);
      check("t1_word1", pop_log[1], 32'hABCDEF01);
    end
    pop_log.delete();

    // 2: back-to-back words in one frame.
    add_word(32'h33333333);
    add_word(32'h44444444);
    send_frame(3, 1'b0);
    wait_drain("t2_drain");
    check("t2_pop_count", pop_log.size(), 32'd2);
    if (pop_log.size() == 2) begin
      check("t2_word0", pop_log[0], 32'h33333333);
      check("t2_word1", pop_log[1], 32'h44444444);
    end
    check("t2_err_cnt", {24'd0, err_cnt}, 32'd0);
    pop_log.delete();

    // 3: short frame of 5 nibbles, then a good frame.
    pulses_before = err_pulses;
    for (int i = 1; i <= 5; i++) nibs.push_back(4'(i));
    send_frame(3, 1'b0);
    check("t3_err_pulses", err_pulses - pulses_before, 32'd1);
    check("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("t3_err_cnt_model", {24'd0, err_cnt}, exp_err_cnt);
    check("t3_no_word", {31'd0, u_if.valid_o}, 32'd0);
    add_word(32'hA5A5A5A5);
    send_frame(3, 1'b0);
    wait_drain("t3_drain");
    check("t3_pop_count", pop_log.size(), 32'd1);
    if (pop_log.size() == 1) check("t3_word", pop_log[0], 32'hA5A5A5A5);
    pop_log.delete();

    // 4: overflow with stalled consumer, then drain and clear.
    @(posedge clk);
    #2 u_if.ready_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) add_word(32'(i));
    send_frame(3, 1'b0);
    @(negedge clk);
    check("t4_overflow_model", {31'd0, ovf}, {31'd0, exp_ovf});
    check("t4_overflow", {31'd0, ovf}, 32'd1);
    check("t4_head", u_if.data_o, 32'd0);
    @(posedge clk);
    #2 u_if.ready_i = 1'b1;
    wait_drain("t4_drain");
    check("t4_pop_count", pop_log.size(), 32'd4);
    for (int i = 0; i < pop_log.size(); i++) check("t4_word", pop_log[i], 32'(i));
    pop_log.delete();
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    exp_ovf = 1'b0;
    exp_err_cnt = 0;
    @(negedge clk);
    check("t4_clr_overflow", {31'd0, ovf}, 32'd0);
    check("t4_clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    // 5: reset after 3 nibbles of an all-ones word.
    pulses_before = err_pulses;
    @(posedge clk);
    #2 sync = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) nib_pulse(4'hF, 3, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    sync = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs("t5_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    add_word(32'h00000000);
    send_frame(3, 1'b0);
    wait_drain("t5_drain");
    check("t5_pop_count", pop_log.size(), 32'd1);
    if (pop_log.size() == 1) check("t5_word", pop_log[0], 32'h00000000);
    check("t5_err_pulses", err_pulses - pulses_before, 32'd0);
    check("t5_err_cnt", {24'd0, err_cnt}, 32'd0);
    pop_log.delete();

    // 6: 100 random words, minimum pclk phase, random data skew.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 10; k++) add_word($urandom);
      send_frame(3, 1'b1);
    end
    wait_drain("t6_drain");
    check("t6_pop_count", pop_log.size(), 32'd100);
    check("t6_err_cnt", {24'd0, err_cnt}, exp_err_cnt);
    check("t6_overflow", {31'd0, ovf}, {31'd0, exp_ovf});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
